// File: rtl/mb8_word_ctl.sv
// Initiator for the 8-bit single-port SPRAM. Turns 16-bit word and 8-bit byte requests
// into big-endian byte accesses behind a req/rdy/ack handshake.
module mb8_word_ctl #(
  parameter int unsigned ASZ = 17,
  parameter int unsigned DSZ = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           wr,
  input  logic           sz,
  input  logic [ASZ-1:0] addr,
  input  logic [DSZ-1:0] wd,
  output logic           rdy,
  output logic           ack,
  output logic [DSZ-1:0] rd,
  output logic [ASZ-1:0] ai,
  output logic [7:0]     vi,
  output logic           we,
  input  logic [7:0]     vo
);

  typedef enum logic [2:0] {StIdle, StW0, StW1, StR0, StR1, StR2, StDone} state_e;

  state_e         state_q, state_d;
  logic           sz_q, sz_d;
  logic [ASZ-1:0] addr_q, addr_d;
  logic [7:0]     lo_q, lo_d;
  logic           rdy_q, rdy_d;
  logic           ack_q, ack_d;
  logic [DSZ-1:0] rd_q, rd_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic [7:0]     vi_q, vi_d;
  logic           we_q, we_d;
  logic [ASZ-1:0] addr_inc;

  // Natural ASZ-bit overflow gives the required wrap to address zero.
  assign addr_inc = addr_q + {{(ASZ-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    sz_d    = sz_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    rdy_d   = 1'b0;
    ack_d   = 1'b0;
    rd_d    = rd_q;
    ai_d    = ai_q;
    vi_d    = vi_q;
    we_d    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts a new request directly so back-to-back ops skip IDLE.
        rdy_d   = 1'b1;
        state_d = StIdle;
        if (req) begin
          rdy_d  = 1'b0;
          sz_d   = sz;
          addr_d = addr;
          lo_d   = wd[7:0];
          ai_d   = addr;
          if (wr) begin
            state_d = StW0;
            we_d    = 1'b1;
            vi_d    = sz ? wd[15:8] : wd[7:0];
          end else begin
            state_d = StR0;
          end
        end
      end
      StW0: begin
        if (sz_q) begin
          state_d = StW1;
          ai_d    = addr_inc;
          vi_d    = lo_q;
          we_d    = 1'b1;
        end else begin
          state_d = StDone;
          rdy_d   = 1'b1;
          ack_d   = 1'b1;
        end
      end
      StW1: begin
        state_d = StDone;
        rdy_d   = 1'b1;
        ack_d   = 1'b1;
      end
      StR0: begin
        state_d = StR1;
        if (sz_q) ai_d = addr_inc;
      end
      StR1: begin
        if (sz_q) begin
          state_d    = StR2;
          rd_d[15:8] = vo;
        end else begin
          state_d = StDone;
          rd_d    = {8'h00, vo};
          rdy_d   = 1'b1;
          ack_d   = 1'b1;
        end
      end
      StR2: begin
        state_d   = StDone;
        rd_d[7:0] = vo;
        rdy_d     = 1'b1;
        ack_d     = 1'b1;
      end
      default: begin
        state_d = StIdle;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      sz_q    <= 1'b0;
      addr_q  <= '0;
      lo_q    <= 8'h00;
      rdy_q   <= 1'b1;
      ack_q   <= 1'b0;
      rd_q    <= '0;
      ai_q    <= '0;
      vi_q    <= 8'h00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sz_q    <= sz_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      ai_q    <= ai_d;
      vi_q    <= vi_d;
      we_q    <= we_d;
    end
  end

  assign rdy = rdy_q;
  assign ack = ack_q;
  assign rd  = rd_q;
  assign ai  = ai_q;
  assign vi  = vi_q;
  assign we  = we_q;

endmodule

// File: tb/tb_mb8_word_ctl.sv
// Bench for mb8_word_ctl: SPRAM model, transaction-level reference model, directed and
// randomized request streams.
module tb_mb8_word_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        sz = 1'b0;
  logic [16:0] addr = '0;
  logic [15:0] wd = '0;
  logic        rdy, ack, we;
  logic [15:0] rd;
  logic [16:0] ai;
  logic [7:0]  vi;
  logic [7:0]  vo;

  int n_checks = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mb8_word_ctl #(.ASZ(17), .DSZ(16)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .wr  (wr),
    .sz  (sz),
    .addr(addr),
    .wd  (wd),
    .rdy (rdy),
    .ack (ack),
    .rd  (rd),
    .ai  (ai),
    .vi  (vi),
    .we  (we),
    .vo  (vo)
  );

  // SPRAM: synchronous write, read data one cycle after the address.
  logic [7:0] mem     [0:131071];
  logic [7:0] ref_mem [0:131071];
  always @(posedge clk) begin
    if (we) mem[ai] <= vi;
    vo <= mem[ai];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one accepted op completes L edges later (byte wr 1, word wr 2,
  // byte rd 2, word rd 3); writes are expected as an ordered list of byte stores.
  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t         exp_q[$];
  wr_t         e;
  bit          m_rdy = 1'b1;
  bit          m_ack = 1'b0;
  logic [15:0] m_rd = '0;
  logic [15:0] p_rd = '0;
  bit          p_wr = 1'b0;
  int          m_left = 0;
  bit          acc_now = 1'b0;

  always @(posedge clk) begin
    acc_now = 1'b0;
    if (!rst) begin
      m_rdy = 1'b1; m_ack = 1'b0; m_rd = '0; m_left = 0;
      exp_q.delete();
    end else if (m_rdy && req) begin
      m_rdy = 1'b0; m_ack = 1'b0; acc_now = 1'b1; p_wr = wr;
      if (wr && sz) begin
        exp_q.push_back('{a: addr, d: wd[15:8]});
        exp_q.push_back('{a: addr + 17'd1, d: wd[7:0]});
        m_left = 2;
      end else if (wr) begin
        exp_q.push_back('{a: addr, d: wd[7:0]});
        m_left = 1;
      end else if (sz) begin
        p_rd = {ref_mem[addr], ref_mem[addr + 17'd1]};
        m_left = 3;
      end else begin
        p_rd = {8'h00, ref_mem[addr]};
        m_left = 2;
      end
    end else if (!m_rdy) begin
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1'b1; m_ack = 1'b1;
        if (!p_wr) m_rd = p_rd;
      end
    end else begin
      m_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rdy", rdy, m_rdy);
      chk("ack", ack, m_ack);
      if (ack === 1'b1) ack_cnt++;
      if (m_rdy) chk("rd", rd, m_rd);
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("we_unexpected", we, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", ai, e.a);
          chk("wr_data", vi, e.d);
          ref_mem[e.a] = e.d;
        end
      end else if (we !== 1'b0) begin
        chk("we_known", we, 0);
      end
      if (m_ack) chk("writes_missing", exp_q.size(), 0);
    end
  end

  // Called at a negedge; returns at the negedge where the DUT shows ack.
  task automatic do_op(input bit w, input bit s, input logic [16:0] a, input logic [15:0] d,
                       output int lat);
    int t;
    req = 1'b1; wr = w; sz = s; addr = a; wd = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!acc_now && t < 8);
    req = 1'b0;
    chk("accept_rdy", rdy, 0);
    lat = 0;
    while (ack !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic set_b2b(input bit w, input int i);
    wr = w; sz = 1'b1; addr = 17'(2 * i);
    wd = {i[7:0], ~i[7:0]};
  endtask

  task automatic b2b(input bit w);
    int i, k, t;
    logic [15:0] exp_rd;
    i = 0; k = 0; t = 0;
    set_b2b(w, 0);
    req = 1'b1;
    while (k < 17 && t < 300) begin
      @(negedge clk);
      t++;
      if (acc_now) begin
        i++;
        if (i < 17) set_b2b(w, i);
        else req = 1'b0;
      end
      if (ack === 1'b1) begin
        exp_rd = {k[7:0], ~k[7:0]};
        if (!w) chk("b2b_rd", rd, exp_rd);
        k++;
      end
    end
    req = 1'b0;
    chk("b2b_acks", k, 17);
    chk("b2b_cycles", t, w ? 51 : 68);
  endtask

  initial begin
    int lat, c0;
    logic [7:0] v0, v1, v4;
    bit w, s;
    logic [16:0] a;
    for (int i = 0; i < 131072; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[17'h100] = 8'h00; mem[17'h101] = 8'h00;
    ref_mem[17'h100] = 8'h00; ref_mem[17'h101] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    chk("rst_rdy", rdy, 1); chk("rst_ack", ack, 0); chk("rst_rd", rd, 0);
    chk("rst_ai", ai, 0);   chk("rst_vi", vi, 0);   chk("rst_we", we, 0);
    rst = 1'b1;
    @(negedge clk);

    do_op(1'b1, 1'b1, 17'h00010, 16'hA55A, lat);
    chk("ww_lat", lat, 2);
    chk("ww_hi", mem[17'h10], 8'hA5); chk("ww_lo", mem[17'h11], 8'h5A);
    do_op(1'b0, 1'b1, 17'h00010, 16'h0000, lat);
    chk("wr_lat", lat, 3); chk("wr_rd", rd, 16'hA55A);

    v4 = mem[17'h4];
    do_op(1'b1, 1'b0, 17'h00003, 16'h12FE, lat);
    chk("bw_lat", lat, 1);
    chk("bw_mem", mem[17'h3], 8'hFE); chk("bw_nb", mem[17'h4], v4);
    do_op(1'b0, 1'b0, 17'h00003, 16'h0000, lat);
    chk("br_lat", lat, 2); chk("br_rd", rd, 16'h00FE);

    do_op(1'b1, 1'b1, 17'h1FFFF, 16'hBEEF, lat);
    chk("wrap_hi", mem[17'h1FFFF], 8'hBE); chk("wrap_lo", mem[17'h0], 8'hEF);
    do_op(1'b0, 1'b1, 17'h1FFFF, 16'h0000, lat);
    chk("wrap_rd", rd, 16'hBEEF);

    b2b(1'b1);
    b2b(1'b0);

    // Request during W1 must be dropped.
    @(negedge clk);
    v0 = mem[17'h300]; v1 = mem[17'h301];
    @(posedge clk); #1 c0 = ack_cnt;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; sz = 1'b1; addr = 17'h200; wd = 16'h1357;
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1; addr = 17'h300; wd = 16'hFFFF;
    @(negedge clk); req = 1'b0;
    chk("busy_ack", ack, 1);
    repeat (4) @(negedge clk);
    chk("busy_m0", mem[17'h300], v0); chk("busy_m1", mem[17'h301], v1);
    chk("busy_hi", mem[17'h200], 8'h13); chk("busy_lo", mem[17'h201], 8'h57);
    @(posedge clk); #1 chk("busy_acks", ack_cnt - c0, 1);

    // Reset sampled at E1 of a word write: only the hi byte lands.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; sz = 1'b1; addr = 17'h100; wd = 16'h7733;
    @(negedge clk); req = 1'b0; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("abort_we", we, 0); chk("abort_rdy", rdy, 1); chk("abort_ack", ack, 0);
    repeat (3) @(negedge clk);
    chk("abort_we2", we, 0);
    do_op(1'b0, 1'b1, 17'h100, 16'h0000, lat);
    chk("abort_lat", lat, 3); chk("abort_rd", rd, 16'h7700);

    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom); s = 1'($urandom);
      a = ($urandom % 4 == 0) ? 17'h1FFFF - 17'($urandom % 2) : 17'($urandom % 64);
      do_op(w, s, a, 16'($urandom), lat);
      chk("rand_lat", lat, w ? (s ? 2 : 1) : (s ? 3 : 2));
      repeat ($urandom % 3) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mb8_word_ctl.md
Name: mb8_word_ctl

Overview:
- Initiator side of the 8-bit single-port memory interface: ai[16:0], vi[7:0], we, vo[7:0], with 1-cycle read latency on the 128K byte SPRAM.
- Converts 16-bit word and 8-bit byte requests from the eForth1 core into sequenced byte accesses.
- Handles byte ordering, address increment and the read-data pipeline delay, so the core sees a simple req/rdy/ack handshake.

Parameters:
- ASZ, 17, memory byte-address width (128K).
- DSZ, 16, word data width; fixed at 2 × 8 bits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- req  input  1  request strobe from core.
- wr  input  1  1 = write, 0 = read; sampled with req.
- sz  input  1  1 = 16-bit word, 0 = 8-bit byte; sampled with req.
- addr  input  ASZ  byte address; sampled with req.
- wd  input  16  write data; byte access uses wd[7:0].
- rdy  output  1  controller idle, can accept req.
- ack  output  1  one-cycle completion pulse.
- rd  output  16  read data; held until next read completes.
- ai  output  ASZ  memory address.
- vi  output  8  memory write data.
- we  output  1  memory write enable.
- vo  input  8  memory read data, valid 1 cycle after ai is presented with we=0.

Behaviour:
- All outputs registered.
- Reset (rst=0 at posedge) values: rdy=1, ack=0, rd=0, ai=0, vi=0, we=0, state IDLE.
- Accept: req=1 and rdy=1 at edge E0 latches wr, sz, addr and wd. rdy drops after E0. req while rdy=0 is ignored, not queued.
- Byte order is big-endian: word at A has hi byte wd[15:8] at A and lo byte wd[7:0] at A+1.
- A+1 is computed mod 2^ASZ: 0x1FFFF+1 = 0x00000. Odd addresses are legal.
- FSM states: IDLE, W0, W1, R0, R1, R2, DONE.
- Word write: IDLE→W0 (ai=A, vi=hi, we=1)→W1 (ai=A+1, vi=lo, we=1)→DONE. Memory writes at E1 and E2. ack=1, rdy=1 for the cycle after E2; a new req can be accepted at E3.
- Byte write: IDLE→W0 (ai=A, vi=wd[7:0], we=1)→DONE. ack after E1.
- Word read: IDLE→R0 (ai=A, we=0)→R1 (ai=A+1, we=0; capture vo into rd[15:8] at E2)→R2 (capture vo into rd[7:0] at E3)→DONE. ack after E3; rd valid in the same cycle as ack.
- Byte read: IDLE→R0 (ai=A)→R1 (rd={8'h00, vo} at E2)→DONE. ack after E2.
- DONE→IDLE after 1 cycle. Back-to-back mode: req=1 during DONE is accepted at that edge, and DONE goes directly to the first state of the new op. So the minimum spacing is one ack per op length + 1.
- Idle levels: we=0, ai and vi hold their last values, rd holds, ack=0.
- Partial results: rd changes only at capture edges. During a word read rd may hold a mixed old/new value until ack; the core samples rd only on ack.
- Reset mid-operation: abort at that edge, with we=0, rdy=1 and no ack. Any byte already written stays in memory. A word write aborted between E1 and E2 leaves only the hi byte updated.
- ack never coincides with rdy=0. Exactly one ack per accepted req unless reset intervenes.

Test Plan:
- Word write A=0x00010, wd=0xA55A, then word read A=0x00010 → we=1 at exactly 2 edges with (0x00010, 0xA5) and (0x00011, 0x5A); read ack 3 edges after accept with rd=0xA55A.
- Byte write A=0x00003, wd=0x12FE, then byte read A=0x00003 → single memory write of 0xFE; rd=0x00FE; ack 1 edge after accept for the write, 2 edges for the read.
- Wrap: word write A=0x1FFFF, wd=0xBEEF → writes 0xBE at 0x1FFFF and 0xEF at 0x00000; word read of 0x1FFFF returns 0xBEEF.
- Back-to-back: hold req=1 across 17 word writes with A=2i, wd={i,~i}, then 17 reads → no dropped or duplicated ack; every rd matches; rdy never high while a memory access is in flight.
- Req while busy: pulse req during W1 with a different address → ignored; memory contents at that address unchanged; one ack only.
- Reset mid-write: rst=0 for one edge between E1 and E2 of a word write to 0x00100 (prior contents 0x0000) → next cycle we=0, rdy=1, no ack; a read returns 0xHH00 with only the hi byte updated.
